// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

    // Largest value that fits in n decimal digits (10^n - 1).
    function automatic logic [63:0] max_display(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// state  | meaning
// IDLE   | waiting for start, captures bin and overflow flag
// CONV   | VAL_W add-3/shift steps
// COMMIT | result stable on bcd/ovf, done pulses for one cycle
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [VAL_W-1:0]         bin,
    output logic                     busy,
    output logic                     done,
    output bcd_digit_t [DIGITS-1:0]  bcd,
    output logic                     ovf
);

    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int CAT_W = 4 * DIGITS + VAL_W;
    localparam logic [63:0] MAX_DISP = max_display(DIGITS);

    scan_state_t               state_q, state_nxt;
    logic [VAL_W-1:0]          sh_q;
    bcd_digit_t [DIGITS-1:0]   bcd_q, bcd_adj;
    logic [CNT_W-1:0]          cnt_q;
    logic                      ovf_q, busy_q, last_bit;
    logic [CAT_W-1:0]          cat;

    assign last_bit = (cnt_q == CNT_W'(VAL_W - 1));
    assign cat      = {bcd_adj, sh_q};

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last_bit) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy_q  <= (state_nxt != IDLE);
            if (state_q == IDLE && start) begin
                sh_q  <= bin;
                bcd_q <= '0;
                cnt_q <= '0;
                ovf_q <= (64'(bin) > MAX_DISP);
            end else if (state_q == CONV) begin
                {bcd_q, sh_q} <= {cat[CAT_W-2:0], 1'b0};
                cnt_q         <= cnt_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = (state_q == COMMIT);
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_dec.sv
// BCD nibble to active-low 7-segment pattern, a..g on bits 6..0.
module seg_dec
    import seg_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (digit)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver: sequential BCD conversion with
// atomic commit, free-running digit scan and one shared decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VAL_W-1:0]   value_i,
    input  logic               load_i,
    input  logic               blank_lz_i,
    output logic               busy_o,
    output logic [6:0]         bcn_o,
    output logic [DIGITS-1:0]  an_o
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                     conv_done, conv_ovf;
    bcd_digit_t [DIGITS-1:0]  conv_bcd, dig_q;
    logic                     ovf_q;
    logic [PRE_W-1:0]         pre_q;
    logic [IDX_W-1:0]         idx_q;
    logic [DIGITS-1:0]        lz;
    logic [6:0]               dec_seg, seg_sel;
    logic [6:0]               bcn_q;
    logic [DIGITS-1:0]        an_q;

    bin2bcd_seq #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load_i),
        .bin   (value_i),
        .busy  (busy_o),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    seg_dec u_dec (
        .digit (dig_q[idx_q]),
        .seg   (dec_seg)
    );

    // lz[i]: digit i and everything above it are zero; digit 0 never qualifies.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz         = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (dig_q[i] == 4'd0);
            lz[i]      = upper_zero & (i != 0);
        end
    end

    always_comb begin
        seg_sel = dec_seg;
        if (ovf_q)                         seg_sel = SEG_DASH;
        else if (blank_lz_i && lz[idx_q])  seg_sel = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '0;
            ovf_q <= 1'b0;
            pre_q <= '0;
            idx_q <= '0;
            bcn_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            if (conv_done) begin
                dig_q <= conv_bcd;
                ovf_q <= conv_ovf;
            end
            if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            bcn_q <= seg_sel;
            an_q  <= ~(DIGITS'(1) << idx_q);
        end
    end

    assign bcn_o = bcn_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table plus hand-written
// sequences for overlapping loads, mid-conversion reset and tear-free update.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int VAL_W  = 14;
    localparam int RDIV   = 4;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100, SB = 7'b1111111, SD = 7'b1111110;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [VAL_W-1:0]  value_i = '0;
    logic              load_i = 1'b0;
    logic              blank_lz_i = 1'b0;
    logic              busy_o;
    logic [6:0]        bcn_o;
    logic [DIGITS-1:0] an_o;

    int checks = 0;
    int errors = 0;

    typedef logic [3:0][6:0] frame_t;
    typedef struct { int digit; logic [6:0] seg; } exp_t;
    typedef struct { logic [VAL_W-1:0] value; logic blank; frame_t segs; } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    seg_scan_ctrl #(.DIGITS(DIGITS), .VAL_W(VAL_W), .REFRESH_DIV(RDIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_i    (value_i),
        .load_i     (load_i),
        .blank_lz_i (blank_lz_i),
        .busy_o     (busy_o),
        .bcn_o      (bcn_o),
        .an_o       (an_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic frame_t mk(input logic [6:0] d3, input logic [6:0] d2,
                                  input logic [6:0] d1, input logic [6:0] d0);
        frame_t f;
        f[3] = d3; f[2] = d2; f[1] = d1; f[0] = d0;
        return f;
    endfunction

    function automatic logic [DIGITS-1:0] an_of(input int d);
        logic [DIGITS-1:0] one;
        one = 1;
        return ~(one << d);
    endfunction

    function automatic int dig_of(input logic [DIGITS-1:0] a);
        for (int i = 0; i < DIGITS; i++) if (a === an_of(i)) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic do_load(input logic [VAL_W-1:0] v, input string nm);
        int n;
        value_i = v;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({nm, " busy_len"}, n, 15);
        tick();
    endtask

    task automatic push_frame(input frame_t f);
        for (int d = 0; d < DIGITS; d++) sb.push_back('{digit: d, seg: f[d]});
    endtask

    task automatic check_frame(input string nm);
        int   n;
        exp_t e;
        n = 0;
        while (an_o !== an_of(0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            timeout({nm, " frame_start"});
            sb.delete();
            return;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            while (an_o !== an_of(e.digit) && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) timeout($sformatf("%s d%0d", nm, e.digit));
            else         chk($sformatf("%s d%0d", nm, e.digit), bcn_o, e.seg);
        end
    endtask

    initial begin
        int n, hi, rises, d;
        logic prev, seen_new;
        frame_t f_old, f_new;

        vecs[0] = '{value: 14'd1234,  blank: 1'b0, segs: mk(S1, S2, S3, S4)};
        vecs[1] = '{value: 14'd7,     blank: 1'b1, segs: mk(SB, SB, SB, S7)};
        vecs[2] = '{value: 14'd0,     blank: 1'b1, segs: mk(SB, SB, SB, S0)};
        vecs[3] = '{value: 14'd0,     blank: 1'b0, segs: mk(S0, S0, S0, S0)};
        vecs[4] = '{value: 14'd7,     blank: 1'b0, segs: mk(S0, S0, S0, S7)};
        vecs[5] = '{value: 14'd10000, blank: 1'b0, segs: mk(SD, SD, SD, SD)};
        vecs[6] = '{value: 14'd9999,  blank: 1'b1, segs: mk(S9, S9, S9, S9)};
        vecs[7] = '{value: 14'd305,   blank: 1'b1, segs: mk(SB, S3, S0, S5)};
        vecs[8] = '{value: 14'd16383, blank: 1'b1, segs: mk(SD, SD, SD, SD)};

        // reset state
        tick(); tick();
        chk("rst busy", busy_o, 0);
        chk("rst an", an_o, 4'b1111);
        chk("rst bcn", bcn_o, SB);
        rst = 1'b0;
        tick();
        chk("post_rst an", an_o, 4'b1110);
        chk("post_rst bcn", bcn_o, S0);

        for (int i = 0; i < 9; i++) begin
            blank_lz_i = vecs[i].blank;
            do_load(vecs[i].value, $sformatf("vec%0d", i));
            push_frame(vecs[i].segs);
            check_frame($sformatf("vec%0d", i));
            if (i == 0) begin
                n = 0;
                while (an_o === an_of(1) && n < 50) begin tick(); n++; end
                n = 0;
                while (an_o !== an_of(1) && n < 50) begin tick(); n++; end
                n = 0;
                while (an_o === an_of(1) && n < 50) begin tick(); n++; end
                chk("dwell d1", n, RDIV);
                chk("after d1", an_o, an_of(2));
            end
        end

        // live blank_lz_i change on the held value 7
        blank_lz_i = 1'b0;
        do_load(14'd7, "live");
        blank_lz_i = 1'b1;
        tick();
        push_frame(mk(SB, SB, SB, S7));
        check_frame("live_blank");

        // load while busy is dropped
        blank_lz_i = 1'b0;
        value_i = 14'd55;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
        hi = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) hi++;
            if (busy_o && !prev) rises++;
            prev = busy_o;
            if (i == 5) begin value_i = 14'd66; load_i = 1'b1; end
            else load_i = 1'b0;
            tick();
        end
        chk("drop busy_len", hi, 15);
        chk("drop busy_pulses", rises, 1);
        push_frame(mk(S0, S0, S5, S5));
        check_frame("drop");

        // reset during conversion
        value_i = 14'd4321;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst busy_before", busy_o, 1);
        rst = 1'b1;
        tick();
        chk("midrst busy", busy_o, 0);
        chk("midrst an", an_o, 4'b1111);
        chk("midrst bcn", bcn_o, SB);
        rst = 1'b0;
        tick();
        chk("midrst rel an", an_o, 4'b1110);
        chk("midrst rel bcn", bcn_o, S0);
        for (int i = 0; i < 20; i++) begin
            if (busy_o !== 1'b0) chk("midrst busy_stays_low", busy_o, 0);
            tick();
        end
        push_frame(mk(S0, S0, S0, S0));
        check_frame("midrst");

        // tear-free switch from 1234 to 8765
        f_old = mk(S1, S2, S3, S4);
        f_new = mk(S8, S7, S6, S5);
        do_load(14'd1234, "tear_pre");
        push_frame(f_old);
        check_frame("tear_pre");
        value_i = 14'd8765;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
        seen_new = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            d = dig_of(an_o);
            if (d < 0) begin
                chk("tear an_onecold", an_o, an_of(0));
            end else if (busy_o) begin
                hi++;
                chk($sformatf("tear busy d%0d", d), bcn_o, f_old[d]);
            end else begin
                if (bcn_o === f_new[d] && f_new[d] !== f_old[d]) seen_new = 1'b1;
                chk($sformatf("tear after d%0d", d), bcn_o, seen_new ? f_new[d] : f_old[d]);
            end
            tick();
        end
        chk("tear busy_len", hi, 15);
        chk("tear switched", seen_new, 1);
        push_frame(f_new);
        check_frame("tear_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
